// File: rtl/apb_reg_slave.sv
// ---------------------------------------------------------------------------
// apb_reg_slave
//
// APB slave with sixteen 8-bit registers:
//   0..11  read/write storage, reset to RST_VAL
//   12     ID      (read-only, returns ID_VAL)
//   13     WCNT    (read-only, count of good writes, wraps at 256)
//   14     ECNT    (read-only, count of writes to read-only regs, saturates)
//   15     LASTERR (read-only, {4'b0, address of last erroring write})
// Reads never error.  A write to 12..15 completes with pslverr=1 and
// leaves storage alone.
//
// Optional feature: define APB_REG_SLAVE_WAIT_EN to insert exactly one
// wait cycle (pready=0) at the start of every access phase.  Without it
// every access completes in its first access cycle.
//
// Handshake: a transfer starts with a setup cycle (psel=1, penable=0)
// seen in IDLE.  It completes on the rising edge where pready=1 while
// psel=penable=1.  pready, pslverr and prdata are combinational and are
// only meaningful (non-zero) in that completing cycle.
//
// Ports:
//   pclk     in   clock, all state updates on the rising edge
//   presetn  in   asynchronous active-low reset
//   psel     in   slave select
//   penable  in   access-phase indicator
//   pwrite   in   1 = write, 0 = read
//   paddr    in   [3:0] register index
//   pwdata   in   [7:0] write data
//   prdata   out  [7:0] read data, 8'h00 unless pready=1
//   pready   out  transfer completes this cycle
//   pslverr  out  transfer error, only ever 1 together with pready
// ---------------------------------------------------------------------------
module apb_reg_slave #(
    parameter logic [7:0] ID_VAL  = 8'hA5,
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input  logic       pclk,
    input  logic       presetn,
    input  logic       psel,
    input  logic       penable,
    input  logic       pwrite,
    input  logic [3:0] paddr,
    input  logic [7:0] pwdata,
    output logic [7:0] prdata,
    output logic       pready,
    output logic       pslverr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // State entered from a setup phase.
`ifdef APB_REG_SLAVE_WAIT_EN
    localparam state_t FIRST_STATE = WAIT;
`else
    localparam state_t FIRST_STATE = ACCESS;
`endif

    state_t     state;
    logic [7:0] regs [0:11];
    logic [7:0] wcnt;
    logic [7:0] ecnt;
    logic [3:0] lasterr;

    logic       setup_phase;
    logic       access_phase;
    logic       completing;
    logic       ro_addr;
    logic       wr_ok;
    logic       wr_err;
    logic [7:0] rd_val;

    assign setup_phase  = psel & ~penable;
    assign access_phase = psel & penable;
    assign ro_addr      = (paddr >= 4'd12);

    // Completion is only possible in ACCESS; penable seen in IDLE without
    // a preceding setup never reaches here, so it has no effect.
    assign completing = (state == ACCESS) & access_phase;
    assign wr_ok      = completing & pwrite & ~ro_addr;
    assign wr_err     = completing & pwrite & ro_addr;

    assign pready  = completing;
    assign pslverr = wr_err;

    // Read mux works off current register contents, so a read right after
    // a counter update already sees the new value.
    always_comb begin
        rd_val = 8'h00;
        case (paddr)
            4'd12:   rd_val = ID_VAL;
            4'd13:   rd_val = wcnt;
            4'd14:   rd_val = ecnt;
            4'd15:   rd_val = {4'b0000, lasterr};
            default: rd_val = regs[paddr];
        endcase
    end

    assign prdata = completing ? rd_val : 8'h00;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state   <= IDLE;
            wcnt    <= 8'h00;
            ecnt    <= 8'h00;
            lasterr <= 4'h0;
            for (int i = 0; i < 12; i++) begin
                regs[i] <= RST_VAL;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (setup_phase) begin
                        state <= FIRST_STATE;
                    end
                end
                WAIT: begin
                    // Anything other than a proper access phase (psel
                    // dropped, or penable still low) abandons the transfer.
                    if (access_phase) begin
                        state <= ACCESS;
                    end else begin
                        state <= IDLE;
                    end
                end
                ACCESS: begin
                    // Either the transfer completes or it was abandoned;
                    // both return to IDLE, which also accepts an immediate
                    // back-to-back setup on the next cycle.
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (wr_ok) begin
                regs[paddr] <= pwdata;
                wcnt        <= wcnt + 8'd1;
            end

            if (wr_err) begin
                if (ecnt != 8'hFF) begin
                    ecnt <= ecnt + 8'd1;
                end
                lasterr <= paddr;
            end
        end
    end

endmodule

// File: doc/apb_reg_slave.md
APB_REG_SLAVE -- requirements
Module: apb_reg_slave

Interface
REQ-001 SHALL have parameter ID_VAL, default 8'hA5, constant returned at register 12.
REQ-002 SHALL have parameter RST_VAL, default 8'h00, reset value of R/W registers 0..11.
REQ-003 SHALL have port pclk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port presetn, input, 1 bit, reset; asynchronous and active-low.
REQ-005 SHALL have port psel, input, 1 bit, slave select from the APB master.
REQ-006 SHALL have port penable, input, 1 bit, access-phase indicator.
REQ-007 SHALL have port pwrite, input, 1 bit, 1=write, 0=read.
REQ-008 SHALL have port paddr, input, 4 bits, register index 0..15.
REQ-009 SHALL have port pwdata, input, 8 bits, write data.
REQ-010 SHALL have port prdata, output, 8 bits, read data.
REQ-011 SHALL have port pready, output, 1 bit, transfer completion.
REQ-012 SHALL have port pslverr, output, 1 bit, transfer error, valid only with pready=1.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, ACCESS.
REQ-014 IDLE: stay while psel=0; move on psel=1 & penable=0 (setup phase) to WAIT if wait states are enabled, else to ACCESS.
REQ-015 WAIT: pready=0 for exactly one cycle with psel=penable=1, then move to ACCESS.
REQ-016 ACCESS: pready=1 combinationally while psel=penable=1; transfer completes at that rising edge; next state SETUP-detect (back-to-back setup accepted) else IDLE.
REQ-017 psel dropped in WAIT or ACCESS before completion SHALL abort to IDLE with no register side effects.
REQ-018 Map: 0..11 R/W storage; 12 ID (RO, ID_VAL); 13 WCNT (RO); 14 ECNT (RO); 15 LASTERR (RO, {4'b0, addr}).
REQ-019 Write to 0..11 at completion SHALL store pwdata, pslverr=0, WCNT+1 modulo 256 (255 -> 0).
REQ-020 Write to 12..15 SHALL leave storage unchanged, pslverr=1, ECNT+1 saturating at 255, LASTERR <= {4'b0, paddr}.
REQ-021 Reads SHALL never error; prdata = addressed register combinationally while pready=1, else 8'h00.
REQ-022 pslverr SHALL be 0 whenever pready=0.
REQ-023 Read of WCNT/ECNT in the transfer after an update SHALL return the updated value (zero bubble).
REQ-024 One transfer at a time; penable=1 seen in IDLE (no setup) SHALL be ignored: pready=0, no side effects.

Reset
REQ-025 presetn=0 SHALL immediately force state IDLE, registers 0..11 to RST_VAL, WCNT=ECNT=LASTERR=8'h00.
REQ-026 During reset: pready=0, pslverr=0, prdata=8'h00; reset mid-transfer discards the transfer.
REQ-027 First setup phase SHALL be accepted on the first rising edge after presetn deasserts.

Configuration
REQ-028 Macro APB_REG_SLAVE_WAIT_EN defined: every transfer SHALL insert one WAIT cycle (2-cycle access phase, setup to completion = 3 edges).
REQ-029 APB_REG_SLAVE_WAIT_EN undefined: no WAIT state; zero-wait access (setup to completion = 2 edges); WAIT unreachable and may be removed.

Verification
REQ-030 Reset, then read addr 0..11 -> prdata=8'h00 each, pslverr=0; read addr 12 -> 8'hA5.
REQ-031 Write addr i = 5*i for i=1..9, read back -> prdata=5*i, pslverr=0; WCNT reads 8'h09.
REQ-032 Write 8'h33 to addr 13 -> pslverr=1 at completion; addr 13 unchanged (WCNT value); ECNT=1; LASTERR=8'h0D.
REQ-033 256 writes to addr 0 -> WCNT=8'h00 (wrap); 300 writes to addr 12 -> ECNT=8'hFF (saturate).
REQ-034 Assert presetn=0 during access phase of write 8'h77 to addr 2 -> addr 2 reads 8'h00, pready=0 during reset.
REQ-035 With APB_REG_SLAVE_WAIT_EN: pready=0 for the first access cycle and 1 for the second; without it: pready=1 in the first access cycle.
